mode_clock_monitor: RTL

//  Receive-side checker for the controller's mode_clock/LD outputs. Measures the

---
 rtl/mode_clock_monitor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mode_clock_monitor.sv
// Receive-side checker for the controller's mode_clock/LD outputs: measures the
// tick period, locks onto one of three known rates, and flags stalls and stuck LED patterns.
module mode_clock_monitor #(
  parameter int CNT_W    = 16,
  parameter int PERIOD_A = 1000,
  parameter int PERIOD_B = 500,
  parameter int PERIOD_C = 200,
  parameter int TOL      = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             mode_clock,
  input  logic [15:0]      LD,
  output logic [1:0]       MODE,
  output logic             MODE_VALID,
  output logic [CNT_W-1:0] PERIOD,
  output logic             TICK,
  output logic             STALL,
  output logic [7:0]       ERR_CNT
);

  typedef enum logic [1:0] {IDLE, FIRST, CHECK, LOCKED} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       mode_q, mode_d;
  logic             mode_valid_q, mode_valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             stall_q, stall_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             mc_q, mc_d;
  logic [15:0]      ld_q, ld_d;

  logic       rise;
  logic       timeout;
  logic [1:0] p_class;

  // Windows are inclusive; A is tested first so overlapping windows resolve to the slowest rate.
  function automatic logic [1:0] classify(input logic [CNT_W-1:0] p);
    int pi;
    pi = int'(p);
    if (pi >= PERIOD_A - TOL && pi <= PERIOD_A + TOL)      classify = 2'b01;
    else if (pi >= PERIOD_B - TOL && pi <= PERIOD_B + TOL) classify = 2'b10;
    else if (pi >= PERIOD_C - TOL && pi <= PERIOD_C + TOL) classify = 2'b11;
    else                                                   classify = 2'b00;
  endfunction

  always_comb begin
    rise    = mode_clock & ~mc_q;
    timeout = (cnt_q == TIMEOUT_C);
    p_class = classify(cnt_q);

    state_d      = state_q;
    cand_d       = cand_q;
    mode_d       = mode_q;
    mode_valid_d = mode_valid_q;
    period_d     = period_q;
    stall_d      = stall_q;
    err_cnt_d    = err_cnt_q;
    ld_d         = ld_q;
    mc_d         = mode_clock;
    tick_d       = rise;

    if (rise)         cnt_d = CNT_W'(1);
    else if (timeout) cnt_d = cnt_q;
    else              cnt_d = cnt_q + CNT_W'(1);

    if (rise) begin
      ld_d    = LD;
      stall_d = 1'b0;
      if (state_q != IDLE) period_d = cnt_q;
      if (state_q == LOCKED && LD == ld_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    // A rising edge always wins over a timeout landing in the same cycle.
    case (state_q)
      IDLE: begin
        if (rise) state_d = FIRST;
      end
      FIRST: begin
        if (rise) begin
          if (p_class != 2'b00) begin
            state_d = CHECK;
            cand_d  = p_class;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (rise) begin
          if (p_class == 2'b00) begin
            state_d = FIRST;
          end else if (p_class == cand_q) begin
            state_d      = LOCKED;
            mode_d       = cand_q;
            mode_valid_d = 1'b1;
          end else begin
            cand_d = p_class;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (p_class != mode_q) begin
            mode_d       = 2'b00;
            mode_valid_d = 1'b0;
            if (p_class == 2'b00) begin
              state_d = FIRST;
            end else begin
              state_d = CHECK;
              cand_d  = p_class;
            end
          end
        end else if (timeout) begin
          state_d      = IDLE;
          stall_d      = 1'b1;
          mode_d       = 2'b00;
          mode_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // mc_q resets high so a mode_clock already high at reset release is not taken as an edge.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      cand_q       <= 2'b00;
      mode_q       <= 2'b00;
      mode_valid_q <= 1'b0;
      period_q     <= '0;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      stall_q      <= 1'b0;
      err_cnt_q    <= 8'd0;
      mc_q         <= 1'b1;
      ld_q         <= 16'd0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      mode_q       <= mode_d;
      mode_valid_q <= mode_valid_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      stall_q      <= stall_d;
      err_cnt_q    <= err_cnt_d;
      mc_q         <= mc_d;
      ld_q         <= ld_d;
    end
  end

  assign MODE       = mode_q;
  assign MODE_VALID = mode_valid_q;
  assign PERIOD     = period_q;
  assign TICK       = tick_q;
  assign STALL      = stall_q;
  assign ERR_CNT    = err_cnt_q;

endmodule
